// File: rtl/patterns_pkg.sv
// Shared definitions for the pattern/address generator: widths, mode codes,
// direction codes and FSM state encoding.
package patterns_pkg;

  localparam int PAT_W     = 12;
  localparam int PAT_RPT_W = 8;

  // Walk order selected by the mode input
  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_PP   = 2'd2;
  localparam logic [1:0] MODE_RSV  = 2'd3;

  // Current walking direction (only meaningful for ping-pong)
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/Binary2Gray.sv
// Binary to reflected-Gray converter, purely combinational.
module Binary2Gray #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/pattern_next_calc.sv
// Combinational successor of the current pattern value. All arithmetic is done
// one bit wider than the data so overflow/underflow is seen instead of wrapping.
module pattern_next_calc
  import patterns_pkg::*;
#(
  parameter int W = PAT_W
) (
  input  logic [W-1:0] i_bin,
  input  logic         i_dir,
  input  logic [1:0]   i_mode,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_step,
  output logic [W-1:0] o_next,
  output logic         o_pass_end,
  output logic         o_dir_next
);

  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W:0]   w_lo_plus;
  logic         w_over;
  logic         w_below;
  logic [W-1:0] w_lo_plus_clamped;

  assign w_sum     = {1'b0, i_bin} + {1'b0, i_step};
  assign w_diff    = {1'b0, i_bin} - {1'b0, i_step};
  assign w_lo_plus = {1'b0, i_lo} + {1'b0, i_step};
  // Going up past hi
  assign w_over    = (w_sum > {1'b0, i_hi});
  // Going down past lo: borrow out of the wide subtract, or landing under lo
  assign w_below   = w_diff[W] || (w_diff[W-1:0] < i_lo);
  // First value of a new ping-pong pass, never beyond hi
  assign w_lo_plus_clamped = (w_lo_plus > {1'b0, i_hi}) ? i_hi : w_lo_plus[W-1:0];

  // Next value, pass-end flag and next direction per walk mode
  always_comb begin
    o_next     = i_bin;
    o_pass_end = 1'b0;
    o_dir_next = i_dir;
    case (i_mode)
      MODE_UP: begin
        o_dir_next = DIR_UP;
        if (w_over) begin
          o_next     = i_lo;
          o_pass_end = 1'b1;
        end else begin
          o_next = w_sum[W-1:0];
        end
      end
      MODE_DOWN: begin
        o_dir_next = DIR_DOWN;
        if (w_below) begin
          o_next     = i_hi;
          o_pass_end = 1'b1;
        end else begin
          o_next = w_diff[W-1:0];
        end
      end
      MODE_PP: begin
        if (i_dir == DIR_UP) begin
          if (!w_over) begin
            o_next     = w_sum[W-1:0];
            o_dir_next = DIR_UP;
          end else if (w_below) begin
            // Window too small to turn around: pass ends, restart at lo
            o_next     = i_lo;
            o_pass_end = 1'b1;
            o_dir_next = DIR_UP;
          end else begin
            o_next     = w_diff[W-1:0];
            o_dir_next = DIR_DOWN;
          end
        end else begin
          if (w_below) begin
            o_next     = w_lo_plus_clamped;
            o_pass_end = 1'b1;
            o_dir_next = DIR_UP;
          end else begin
            o_next     = w_diff[W-1:0];
            o_dir_next = DIR_DOWN;
          end
        end
      end
      default: begin
        o_next     = i_bin;
        o_pass_end = 1'b0;
        o_dir_next = i_dir;
      end
    endcase
  end

endmodule

// File: rtl/pattern_addr_gen.sv
// Programmable window walker: emits lo..hi by step in up/down/ping-pong order
// for passes+1 passes under a valid/ready handshake, with a Gray-coded copy.
module pattern_addr_gen
  import patterns_pkg::*;
#(
  parameter int W     = PAT_W,
  parameter int RPT_W = PAT_RPT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [W-1:0]     i_lo,
  input  logic [W-1:0]     i_hi,
  input  logic [W-1:0]     i_step,
  input  logic [RPT_W-1:0] i_passes,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [W-1:0]     o_out_bin,
  output logic [W-1:0]     o_out_gray,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [RPT_W-1:0] CNT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [W-1:0]     r_lo, w_lo_nxt;
  logic [W-1:0]     r_hi, w_hi_nxt;
  logic [W-1:0]     r_step, w_step_nxt;
  logic [RPT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;
  logic [W-1:0]     r_bin, w_bin_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [W-1:0]     w_calc_next;
  logic             w_calc_pass_end;
  logic             w_calc_dir;
  logic             w_beat;
  logic             w_cfg_legal;

  assign w_beat      = r_valid && i_out_ready;
  assign w_cfg_legal = (i_mode != MODE_RSV) && (i_lo <= i_hi) && (i_step != {W{1'b0}});

  pattern_next_calc #(.W(W)) u_next (
    .i_bin      (r_bin),
    .i_dir      (r_dir),
    .i_mode     (r_mode),
    .i_lo       (r_lo),
    .i_hi       (r_hi),
    .i_step     (r_step),
    .o_next     (w_calc_next),
    .o_pass_end (w_calc_pass_end),
    .o_dir_next (w_calc_dir)
  );

  Binary2Gray #(.W(W)) u_gray (
    .i_bin  (r_bin),
    .o_gray (o_out_gray)
  );

  // State, configuration and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_UP;
      r_lo    <= {W{1'b0}};
      r_hi    <= {W{1'b0}};
      r_step  <= {W{1'b0}};
      r_cnt   <= {RPT_W{1'b0}};
      r_dir   <= DIR_UP;
      r_bin   <= {W{1'b0}};
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_bin   <= w_bin_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-register logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_bin_nxt   = r_bin;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (i_start) begin
          if (w_cfg_legal) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = i_mode;
            w_lo_nxt    = i_lo;
            w_hi_nxt    = i_hi;
            w_step_nxt  = i_step;
            w_cnt_nxt   = i_passes;
            w_valid_nxt = 1'b1;
            if (i_mode == MODE_DOWN) begin
              w_bin_nxt = i_hi;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_bin_nxt = i_lo;
              w_dir_nxt = DIR_UP;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_beat) begin
          if (w_calc_pass_end && (r_cnt == {RPT_W{1'b0}})) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_bin_nxt = w_calc_next;
            w_dir_nxt = w_calc_dir;
            if (w_calc_pass_end) begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end else begin
              w_cnt_nxt = r_cnt;
            end
          end
        end else begin
          w_bin_nxt = r_bin;
        end
        // Abort overrides everything, including a final-beat DONE
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          w_err_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_out_valid = r_valid;
  assign o_out_bin   = r_bin;
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_pattern_addr_gen.sv
// Directed self-checking bench for pattern_addr_gen.
module tb_pattern_addr_gen;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [11:0] i_lo = 12'd0;
  logic [11:0] i_hi = 12'd0;
  logic [11:0] i_step = 12'd0;
  logic [7:0]  i_passes = 8'd0;
  logic        i_out_ready = 1'b0;
  logic        o_out_valid;
  logic [11:0] o_out_bin;
  logic [11:0] o_out_gray;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int failures = 0;
  logic [11:0] got_bin[$];
  logic [11:0] got_gray[$];

  pattern_addr_gen dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .i_lo        (i_lo),
    .i_hi        (i_hi),
    .i_step      (i_step),
    .i_passes    (i_passes),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_bin   (o_out_bin),
    .o_out_gray  (o_out_gray),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle with the given config, then scramble config inputs
  task automatic do_start(input logic [1:0] m, input logic [11:0] lo, input logic [11:0] hi,
                          input logic [11:0] st, input logic [7:0] ps);
    i_mode = m; i_lo = lo; i_hi = hi; i_step = st; i_passes = ps;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_mode = 2'd3; i_lo = 12'hABC; i_hi = 12'h001; i_step = 12'd0; i_passes = 8'd77;
  endtask

  // Record beats (ready held) until done or the cycle budget runs out
  task automatic collect(input int max_cyc, output int last_beat, output int done_cyc);
    got_bin.delete(); got_gray.delete();
    last_beat = -1; done_cyc = -1;
    for (int c = 0; c < max_cyc; c++) begin
      if (o_out_valid && i_out_ready) begin
        got_bin.push_back(o_out_bin);
        got_gray.push_back(o_out_gray);
        last_beat = c;
      end
      if (o_done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      checks++; failures++;
      $display("FAIL collect_timeout: no done within %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({o_out_valid, o_out_bin, o_out_gray, o_busy, o_done, o_err} !== 28'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b bin=%h gray=%h busy=%b done=%b err=%b, want all 0",
               o_out_valid, o_out_bin, o_out_gray, o_busy, o_done, o_err);
    end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_up();
    int lb, dc;
    logic [11:0] exp_v[6] = '{12'd2, 12'd5, 12'd8, 12'd2, 12'd5, 12'd8};
    i_out_ready = 1'b1;
    do_start(2'd0, 12'd2, 12'd10, 12'd3, 8'd1);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bin !== 12'd2 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL up_latency: got v=%b bin=%h busy=%b, want 1 002 1", o_out_valid, o_out_bin, o_busy);
    end
    collect(40, lb, dc);
    checks++;
    if (got_bin.size() != 6) begin
      failures++;
      $display("FAIL up_count: got %0d beats, want 6", got_bin.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_bin[i] !== exp_v[i]) begin
          failures++;
          $display("FAIL up_value[%0d]: got %h want %h", i, got_bin[i], exp_v[i]);
        end
      end
      checks++;
      if (got_gray[1] !== 12'h007 || got_gray[2] !== 12'h00C) begin
        failures++;
        $display("FAIL up_gray: got %h,%h want 007,00C", got_gray[1], got_gray[2]);
      end
    end
    checks++;
    if (dc != lb + 1 || o_out_valid !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL up_done_timing: done_cyc=%0d last_beat=%0d v=%b busy=%b, want done one cycle after last beat, v=0 busy=0",
               dc, lb, o_out_valid, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL up_done_pulse: got done=%b busy=%b a cycle later, want 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_pingpong();
    int lb, dc;
    logic [11:0] exp_v[7] = '{12'd0, 12'd2, 12'd4, 12'd6, 12'd4, 12'd2, 12'd0};
    i_out_ready = 1'b1;
    do_start(2'd2, 12'd0, 12'd6, 12'd2, 8'd0);
    collect(40, lb, dc);
    checks++;
    if (got_bin.size() != 7) begin
      failures++;
      $display("FAIL pp_count: got %0d beats, want 7", got_bin.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (got_bin[i] !== exp_v[i]) begin
          failures++;
          $display("FAIL pp_value[%0d]: got %h want %h", i, got_bin[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (dc != lb + 1) begin
      failures++;
      $display("FAIL pp_done_timing: done_cyc=%0d last_beat=%0d, want done+1", dc, lb);
    end
    @(negedge clk);
  endtask

  task automatic test_down_ready_toggle();
    i_out_ready = 1'b0;
    do_start(2'd1, 12'h000, 12'hFFF, 12'h800, 8'd0);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bin !== 12'hFFF) begin
      failures++;
      $display("FAIL down_first: got v=%b bin=%h want 1 FFF", o_out_valid, o_out_bin);
    end
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bin !== 12'hFFF) begin
      failures++;
      $display("FAIL down_hold1: got v=%b bin=%h want 1 FFF", o_out_valid, o_out_bin);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bin !== 12'h7FF) begin
      failures++;
      $display("FAIL down_second: got v=%b bin=%h want 1 7FF", o_out_valid, o_out_bin);
    end
    @(negedge clk);
    checks++;
    if (o_out_valid !== 1'b1 || o_out_bin !== 12'h7FF || o_done !== 1'b0) begin
      failures++;
      $display("FAIL down_hold2: got v=%b bin=%h done=%b want 1 7FF 0", o_out_valid, o_out_bin, o_done);
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL down_done: got done=%b v=%b want 1 0 (no wrap after 7FF)", o_done, o_out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [1:0]  m[3]  = '{2'd0, 2'd0, 2'd3};
    logic [11:0] lo[3] = '{12'd9, 12'd1, 12'd1};
    logic [11:0] hi[3] = '{12'd3, 12'd5, 12'd5};
    logic [11:0] st[3] = '{12'd1, 12'd0, 12'd1};
    i_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_start(m[i], lo[i], hi[i], st[i], 8'd0);
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse[%0d]: got err=%b busy=%b v=%b want 1 0 0", i, o_err, o_busy, o_out_valid);
      end
      @(negedge clk);
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL err_clear[%0d]: got err=%b busy=%b want 0 0", i, o_err, o_busy);
      end
    end
    // start and stop together in IDLE: start wins
    i_stop = 1'b1;
    do_start(2'd0, 12'd0, 12'd9, 12'd1, 8'd0);
    checks++;
    if (o_busy !== 1'b1 || o_out_valid !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_idle: got busy=%b v=%b err=%b want 1 1 0", o_busy, o_out_valid, o_err);
    end
    @(negedge clk);
    i_stop = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_after_start: got busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_stop_and_reset();
    logic saw_done = 1'b0;
    i_out_ready = 1'b1;
    do_start(2'd0, 12'd0, 12'd100, 12'd1, 8'd0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_out_bin !== 12'(k) || o_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stop_value[%0d]: got v=%b bin=%h want 1 %h", k, o_out_valid, o_out_bin, 12'(k));
      end
      if (k == 4) i_stop = 1'b1;
      @(negedge clk);
    end
    i_stop = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle: got busy=%b v=%b done=%b want 0 0 0", o_busy, o_out_valid, o_done);
    end
    for (int k = 0; k < 4; k++) begin
      if (o_done) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_no_done: got done pulse after stop, want none");
    end
    do_start(2'd0, 12'd0, 12'd100, 12'd1, 8'd0);
    @(negedge clk); @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    checks++;
    if ({o_out_valid, o_out_bin, o_out_gray, o_busy, o_done, o_err} !== 28'd0) begin
      failures++;
      $display("FAIL reset_midrun: got v=%b bin=%h gray=%h busy=%b done=%b err=%b want all 0",
               o_out_valid, o_out_bin, o_out_gray, o_busy, o_done, o_err);
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_run_single();
    int lb, dc;
    i_out_ready = 1'b0;
    do_start(2'd0, 12'd7, 12'd7, 12'd1, 8'd2);
    i_mode = 2'd3; i_lo = 12'd0; i_hi = 12'd0; i_step = 12'd0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b1 || o_out_bin !== 12'd7 || o_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run: got err=%b busy=%b v=%b bin=%h want 0 1 1 007", o_err, o_busy, o_out_valid, o_out_bin);
    end
    i_out_ready = 1'b1;
    collect(40, lb, dc);
    checks++;
    if (got_bin.size() != 3) begin
      failures++;
      $display("FAIL single_count: got %0d beats, want 3", got_bin.size());
    end else begin
      checks++;
      if (got_bin[0] !== 12'd7 || got_bin[1] !== 12'd7 || got_bin[2] !== 12'd7) begin
        failures++;
        $display("FAIL single_values: got %h %h %h want 007 x3", got_bin[0], got_bin[1], got_bin[2]);
      end
    end
    checks++;
    if (dc != lb + 1) begin
      failures++;
      $display("FAIL single_done_timing: done_cyc=%0d last_beat=%0d want done+1", dc, lb);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_up();
    test_pingpong();
    test_down_ready_toggle();
    test_errors();
    test_stop_and_reset();
    test_start_in_run_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
